quiz_round_controller: RTL and testbench
========================================

QUIZ_ROUND_CONTROLLER -- requirements
Module: quiz_round_controller

Interface
REQ-001 Parameter NUM_QUESTIONS, default 8: questions per round, range 1..8.
REQ-002 Parameter TICK_DIV, default 100_000_000: clk cycles per one-second tick, minimum 2.
REQ-003 Parameter TIME_LIMIT, default 10: seconds allowed per question, range 1..15.
REQ-004 Parameter REVEAL_TIME, default 2: seconds the result is shown, range 1..15.
REQ-005 clk  in  1  system clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a round.
REQ-008 answer_valid  in  1  one-cycle pulse: the answer selector confirmed a choice.
REQ-009 answer_code  in  3  selector code; 0 = nothing selected, 1..7 = choice.
REQ-010 correct_code  in  3  expected code for the current question_index, from the question ROM.
REQ-011 question_index  out  3  current question, 0..NUM_QUESTIONS-1.
REQ-012 selector_enable  out  1  high only while answers are accepted (ASK).
REQ-013 seconds_left  out  4  remaining seconds for the current question.
REQ-014 score  out  4  count of correct answers in this round.
REQ-015 result_valid  out  1  high throughout REVEAL.
REQ-016 result_correct  out  1  verdict for the last question; meaningful only when result_valid is high.
REQ-017 game_over  out  1  high throughout DONE.

Function
REQ-018 FSM states: IDLE, ASK, REVEAL, DONE; registered outputs only, no combinational input-to-output paths.
REQ-019 IDLE: selector_enable=0, seconds_left=0; start -> ASK with question_index=0, score=0, seconds_left=TIME_LIMIT, tick counter=0.
REQ-020 Tick counter: runs 0..TICK_DIV-1 in ASK and REVEAL; tick asserted on the cycle it equals TICK_DIV-1, then it wraps to 0; it clears on every state entry.
REQ-021 ASK: selector_enable=1; on each tick seconds_left decrements by 1.
REQ-022 ASK, answer_valid=1 with answer_code!=0 -> REVEAL next cycle; result_correct=(answer_code==correct_code); if correct, score increments by 1.
REQ-023 ASK, answer_valid=1 with answer_code==0: ignored; no state, score or timer change.
REQ-024 ASK timeout: tick while seconds_left==1 -> seconds_left=0 and REVEAL with result_correct=0; score unchanged.
REQ-025 A valid answer and a timeout tick in the same cycle: the answer wins; it is scored per REQ-022.
REQ-026 Entering REVEAL loads seconds_left=REVEAL_TIME; it decrements on each tick.
REQ-027 REVEAL, tick while seconds_left==1: if question_index==NUM_QUESTIONS-1 -> DONE, else question_index increments and the FSM enters ASK with seconds_left=TIME_LIMIT.
REQ-028 REVEAL and DONE ignore answer_valid.
REQ-029 DONE: score, question_index and result_correct hold; seconds_left=0; start -> ASK with the same initialisation as REQ-019.
REQ-030 start is ignored in ASK and REVEAL.
REQ-031 score saturates at 15 and never wraps; question_index never exceeds NUM_QUESTIONS-1.

Reset
REQ-032 reset=1 at any clock edge, in any state, forces on the next edge: state IDLE, question_index=0, score=0, seconds_left=0, selector_enable=0, result_valid=0, result_correct=0, game_over=0, tick counter=0.
REQ-033 reset takes priority over start, answer_valid and tick in the same cycle.

Verification (TICK_DIV=4, TIME_LIMIT=3, REVEAL_TIME=2, NUM_QUESTIONS=2)
REQ-034 reset, then start; answer_valid with code 3 while correct_code=3 in cycle 2 -> REVEAL next cycle, result_correct=1, score=1, seconds_left=2.
REQ-035 start; no answer -> seconds_left goes 3,2,1,0 on ticks at cycles 4,8,12; REVEAL with result_correct=0, score=0.
REQ-036 answer_valid with code 2 (correct_code=2) on the same cycle as the final timeout tick -> result_correct=1, score=1.
REQ-037 Play 2 questions (right, wrong) -> after the second reveal, game_over=1, score=1, question_index=1; a second start -> ASK, score=0, question_index=0.
REQ-038 answer_valid with code 0 in ASK -> no change; reset asserted mid-REVEAL -> all outputs at REQ-032 values on the next edge.

Source files
------------

// File: rtl/quiz_round_controller.sv
// quiz_round_controller: question timer, scoring and reveal sequencing for one quiz round.
//
// state   | meaning
// IDLE    | waiting for start after reset
// ASK     | selector enabled, question timer counting down once per tick
// REVEAL  | verdict shown; seconds_left==0 here marks a timeout, reload follows next cycle
// DONE    | round finished; score, question_index and verdict held until next start
module quiz_round_controller #(
  parameter int NUM_QUESTIONS = 8,
  parameter int TICK_DIV      = 100_000_000,
  parameter int TIME_LIMIT    = 10,
  parameter int REVEAL_TIME   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       answer_valid,
  input  logic [2:0] answer_code,
  input  logic [2:0] correct_code,
  output logic [2:0] question_index,
  output logic       selector_enable,
  output logic [3:0] seconds_left,
  output logic [3:0] score,
  output logic       result_valid,
  output logic       result_correct,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASK    = 2'd1;
  localparam logic [1:0] S_REVEAL = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [3:0]    TL        = 4'(TIME_LIMIT);
  localparam logic [3:0]    RT        = 4'(REVEAL_TIME);
  localparam logic [2:0]    LAST_Q    = 3'(NUM_QUESTIONS - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          answered;
  logic          hit;

  // tick_cnt is held at zero outside ASK/REVEAL, so tick cannot fire there
  assign tick     = (tick_cnt == TICK_LAST);
  assign answered = answer_valid && (answer_code != 3'd0);
  assign hit      = (answer_code == correct_code);

  // Round sequencing, one-second timebase and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      tick_cnt        <= '0;
      question_index  <= 3'd0;
      selector_enable <= 1'b0;
      seconds_left    <= 4'd0;
      score           <= 4'd0;
      result_valid    <= 1'b0;
      result_correct  <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      if (state == S_ASK || state == S_REVEAL)
        tick_cnt <= tick ? '0 : tick_cnt + TICK_ONE;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_ASK;
            tick_cnt        <= '0;
            question_index  <= 3'd0;
            score           <= 4'd0;
            seconds_left    <= TL;
            selector_enable <= 1'b1;
            result_valid    <= 1'b0;
            result_correct  <= 1'b0;
            game_over       <= 1'b0;
          end
        end

        S_ASK: begin
          // an answer beats a simultaneous timeout tick
          if (answered) begin
            state           <= S_REVEAL;
            tick_cnt        <= '0;
            selector_enable <= 1'b0;
            result_valid    <= 1'b1;
            result_correct  <= hit;
            seconds_left    <= RT;
            if (hit && score != 4'd15)
              score <= score + 4'd1;
          end else if (tick) begin
            if (seconds_left <= 4'd1) begin
              state           <= S_REVEAL;
              tick_cnt        <= '0;
              selector_enable <= 1'b0;
              result_valid    <= 1'b1;
              result_correct  <= 1'b0;
              seconds_left    <= 4'd0;
            end else begin
              seconds_left <= seconds_left - 4'd1;
            end
          end
        end

        S_REVEAL: begin
          // after a timeout the expired 0 is shown for one cycle, then the reveal time loads
          if (seconds_left == 4'd0) begin
            seconds_left <= RT;
            tick_cnt     <= '0;
          end else if (tick) begin
            if (seconds_left == 4'd1) begin
              tick_cnt     <= '0;
              result_valid <= 1'b0;
              if (question_index >= LAST_Q) begin
                state        <= S_DONE;
                seconds_left <= 4'd0;
                game_over    <= 1'b1;
              end else begin
                state           <= S_ASK;
                question_index  <= question_index + 3'd1;
                seconds_left    <= TL;
                selector_enable <= 1'b1;
              end
            end else begin
              seconds_left <= seconds_left - 4'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_controller.sv
// tb_quiz_round_controller: vector table, directed multi-cycle sequences and
// randomized play against an age-based reference model of the round rules.
module tb_quiz_round_controller;

  localparam int NQ = 2;
  localparam int TD = 4;
  localparam int TL = 3;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       reset, start, answer_valid;
  logic [2:0] answer_code, correct_code;
  logic [2:0] question_index;
  logic       selector_enable;
  logic [3:0] seconds_left;
  logic [3:0] score;
  logic       result_valid, result_correct, game_over;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  quiz_round_controller #(
    .NUM_QUESTIONS(NQ), .TICK_DIV(TD), .TIME_LIMIT(TL), .REVEAL_TIME(RT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .answer_valid(answer_valid), .answer_code(answer_code), .correct_code(correct_code),
    .question_index(question_index), .selector_enable(selector_enable),
    .seconds_left(seconds_left), .score(score),
    .result_valid(result_valid), .result_correct(result_correct), .game_over(game_over)
  );

  // Reference model: phase plus cycles spent in it; remaining seconds are
  // derived arithmetically as limit - age/TD.
  localparam int P_IDLE = 0, P_ASK = 1, P_REV = 2, P_DONE = 3;
  int m_phase = P_IDLE, m_age = 0, m_q = 0, m_score = 0;
  bit m_rc = 0, m_zero = 0;

  task automatic model_edge(input bit r, input bit s, input bit av, input int code, input int cc);
    bit tick_now;
    tick_now = (m_age % TD) == TD - 1;
    if (r) begin
      m_phase = P_IDLE; m_age = 0; m_q = 0; m_score = 0; m_rc = 0; m_zero = 0;
      return;
    end
    case (m_phase)
      P_IDLE, P_DONE:
        if (s) begin
          m_phase = P_ASK; m_age = 0; m_q = 0; m_score = 0; m_rc = 0;
        end
      P_ASK:
        if (av && code != 0) begin
          m_phase = P_REV; m_age = 0; m_zero = 0; m_rc = (code == cc);
          if (m_rc && m_score < 15) m_score++;
        end else if (tick_now && (TL - m_age / TD) == 1) begin
          m_phase = P_REV; m_age = 0; m_zero = 1; m_rc = 0;
        end else m_age++;
      default:
        if (m_zero) begin
          m_zero = 0; m_age = 0;
        end else if (tick_now && (RT - m_age / TD) == 1) begin
          if (m_q == NQ - 1) m_phase = P_DONE;
          else begin m_q++; m_phase = P_ASK; end
          m_age = 0;
        end else m_age++;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int q, input int sel, input int sl,
                           input int sc, input int rv, input int rc, input int go);
    chk({tag, " question_index"}, question_index, q);
    chk({tag, " selector_enable"}, selector_enable, sel);
    chk({tag, " seconds_left"}, seconds_left, sl);
    chk({tag, " score"}, score, sc);
    chk({tag, " result_valid"}, result_valid, rv);
    chk({tag, " result_correct"}, result_correct, rc);
    chk({tag, " game_over"}, game_over, go);
  endtask

  task automatic check_model(input string tag);
    int sl;
    sl = 0;
    if (m_phase == P_ASK) sl = TL - m_age / TD;
    else if (m_phase == P_REV) sl = m_zero ? 0 : RT - m_age / TD;
    check_all(tag, m_q, int'(m_phase == P_ASK), sl, m_score,
              int'(m_phase == P_REV), int'(m_rc), int'(m_phase == P_DONE));
  endtask

  // drive one cycle's inputs, let the edge happen, sample on the falling edge
  task automatic step(input bit r, input bit s, input bit av, input logic [2:0] code,
                      input logic [2:0] cc);
    reset = r; start = s; answer_valid = av; answer_code = code; correct_code = cc;
    @(posedge clk);
    model_edge(r, s, av, int'(code), int'(cc));
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 3'd0);
  endtask

  typedef struct {
    bit r, s, av;
    logic [2:0] code, cc;
    int q, sel, sl, sc, rv, rc, go;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset = 1'b0; start = 1'b0; answer_valid = 1'b0;
    answer_code = 3'd0; correct_code = 3'd0;

    //          r  s  av code cc   q sel sl sc rv rc go
    vecs[0] = '{1, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 3'd0, 3'd0, 0, 1, 3, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 3'd0, 3'd3, 0, 1, 3, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 3'd0, 3'd3, 0, 1, 3, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 3'd3, 3'd3, 0, 0, 2, 1, 1, 1, 0};
    vecs[5] = '{0, 1, 1, 3'd5, 3'd3, 0, 0, 2, 1, 1, 1, 0};
    vecs[6] = '{0, 0, 0, 3'd0, 3'd0, 0, 0, 2, 1, 1, 1, 0};
    vecs[7] = '{1, 1, 1, 3'd3, 3'd3, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{0, 0, 1, 3'd3, 3'd3, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].av, vecs[i].code, vecs[i].cc);
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].sel, vecs[i].sl,
                vecs[i].sc, vecs[i].rv, vecs[i].rc, vecs[i].go);
    end

    // timeout: 3,2,1 on ticks, then REVEAL showing 0, then reveal time loads
    step(1, 0, 0, 3'd0, 3'd0);
    step(0, 1, 0, 3'd0, 3'd0);
    idle_steps(3);  check_all("to_age3", 0, 1, 3, 0, 0, 0, 0);
    idle_steps(1);  check_all("to_age4", 0, 1, 2, 0, 0, 0, 0);
    idle_steps(4);  check_all("to_age8", 0, 1, 1, 0, 0, 0, 0);
    idle_steps(4);  check_all("to_expire", 0, 0, 0, 0, 1, 0, 0);
    idle_steps(1);  check_all("to_reload", 0, 0, 2, 0, 1, 0, 0);

    // answer on the same cycle as the final timeout tick
    step(1, 0, 0, 3'd0, 3'd0);
    step(0, 1, 0, 3'd0, 3'd0);
    idle_steps(11); check_all("race_pre", 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 3'd2, 3'd2);
    check_all("race_ans", 0, 0, 2, 1, 1, 1, 0);

    // full round: right then wrong, DONE holds, restart
    step(1, 0, 0, 3'd0, 3'd0);
    step(0, 1, 0, 3'd0, 3'd0);
    step(0, 0, 1, 3'd1, 3'd1);  check_all("rnd_q0", 0, 0, 2, 1, 1, 1, 0);
    idle_steps(7);              check_all("rnd_q0_end", 0, 0, 1, 1, 1, 1, 0);
    idle_steps(1);              check_all("rnd_ask1", 1, 1, 3, 1, 0, 1, 0);
    step(0, 0, 1, 3'd2, 3'd1);  check_all("rnd_q1", 1, 0, 2, 1, 1, 0, 0);
    idle_steps(8);              check_all("rnd_done", 1, 0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 3'd4, 3'd4);  check_all("rnd_done_av", 1, 0, 0, 1, 0, 0, 1);
    step(0, 1, 0, 3'd0, 3'd0);  check_all("rnd_restart", 0, 1, 3, 0, 0, 0, 0);

    // randomized play against the reference model
    for (int i = 0; i < 3000; i++) begin
      bit r, s, av;
      logic [2:0] code, cc;
      r    = ($urandom_range(0, 99) == 0);
      s    = ($urandom_range(0, 19) == 0);
      av   = ($urandom_range(0, 5) == 0);
      code = 3'($urandom_range(0, 7));
      cc   = $urandom_range(0, 1) ? code : 3'($urandom_range(0, 7));
      step(r, s, av, code, cc);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
